bayer_stream_gen: RTL

Raster source for the camera capture path. Generates a raw 12-bit Bayer pixel stream with data-valid, column/row counters and frame/line valids, in the same format the CCD capture stage delivers to the image processing module. Used for bring-up and regression of the processing pipeline without a sensor, selected by a mux in front of the processing module.

---
 rtl/cam_pkg.sv | 32 +++
 rtl/bayer_pattern_gen.sv | 51 +++++
 rtl/bayer_stream_gen.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/cam_pkg.sv
// Shared types and constants for the camera capture path test-pattern source.
package cam_pkg;

    localparam int unsigned PIX_W = 12;
    localparam int unsigned CNT_W = 11;

    // Raster generator states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VBLANK = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_HBLANK = 2'd3
    } state_e;

    // Pattern selection, as presented on iMODE
    typedef enum logic [1:0] {
        MODE_SOLID = 2'd0,
        MODE_RAMP  = 2'd1,
        MODE_BARS  = 2'd2,
        MODE_NOISE = 2'd3
    } mode_e;

    // Noise source: Fibonacci LFSR x^12+x^6+x^4+x+1, taps on bits 11,5,3,0
    localparam logic [PIX_W-1:0] LFSR_SEED = 12'hACE;
    localparam logic [PIX_W-1:0] LFSR_TAPS = 12'h829;

    // One LFSR shift: feedback is the parity of the tapped bits
    function automatic logic [PIX_W-1:0] lfsr_step(input logic [PIX_W-1:0] s);
        return {s[PIX_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/bayer_pattern_gen.sv
// Combinational pixel pattern for one raster position.
// Mode 3 is LFSR noise only when BAYER_GEN_LFSR_EN is defined; otherwise it repeats the solid level.
module bayer_pattern_gen
    import cam_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 1280
) (
    input  mode_e            mode,
    input  logic [CNT_W-1:0] x,
    input  logic [CNT_W-1:0] y,
    input  logic [PIX_W-1:0] level,
`ifdef BAYER_GEN_LFSR_EN
    input  logic [PIX_W-1:0] lfsr,
`endif
    output logic [PIX_W-1:0] pix_c
);

    // Eight bars across the active width; guard tiny widths from a zero divisor
    localparam int unsigned BAR_W = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;

    logic [2:0] bar;
    logic       site_on;

    // Bar colour {R,G,B} = bar index, sampled through the Bayer site of (x,y)
    always_comb begin
        bar = 3'(x / CNT_W'(BAR_W));
        case ({y[0], x[0]})
            2'b00:   site_on = bar[1];
            2'b01:   site_on = bar[2];
            2'b10:   site_on = bar[0];
            default: site_on = bar[1];
        endcase
    end

    // Pattern select
    always_comb begin
        pix_c = '0;
        case (mode)
            MODE_SOLID: pix_c = level;
            MODE_RAMP:  pix_c = PIX_W'({1'b0, x} + {1'b0, y});
            MODE_BARS:  pix_c = site_on ? {PIX_W{1'b1}} : '0;
`ifdef BAYER_GEN_LFSR_EN
            MODE_NOISE: pix_c = lfsr;
`else
            MODE_NOISE: pix_c = level;
`endif
            default:    pix_c = level;
        endcase
    end

endmodule

// File: rtl/bayer_stream_gen.sv
// Raw Bayer test-pattern raster source matching the CCD capture stage output format.
// Optional feature macro: BAYER_GEN_LFSR_EN (mode 3 becomes LFSR noise).
module bayer_stream_gen
    import cam_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned V_ACTIVE = 960,
    parameter int unsigned H_BLANK  = 160,
    parameter int unsigned V_BLANK  = 2000
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iRUN,
    input  logic [1:0]       iMODE,
    input  logic [PIX_W-1:0] iLEVEL,
    output logic [PIX_W-1:0] oDATA,
    output logic             oDVAL,
    output logic [CNT_W-1:0] oX_Cont,
    output logic [CNT_W-1:0] oY_Cont,
    output logic             oFVAL,
    output logic [31:0]      oFrame_Cont
);

    localparam int unsigned BLK_MAX = (V_BLANK > H_BLANK) ? V_BLANK : H_BLANK;
    localparam int unsigned BLK_W   = $clog2(BLK_MAX + 1);
    localparam int unsigned FC_W    = 32;

    state_e             state_q, state_d;
    logic [BLK_W-1:0]   blk_q, blk_d;
    logic [CNT_W-1:0]   x_q, x_d;
    logic [CNT_W-1:0]   y_q, y_d;
    mode_e              mode_q, mode_d;
    logic [PIX_W-1:0]   level_q, level_d;
    logic [FC_W-1:0]    frame_q, frame_d;
    logic [PIX_W-1:0]   data_q, data_d;
    logic               dval_q, dval_d;
    logic               fval_q, fval_d;
    logic [PIX_W-1:0]   pix_c;

    // Next state, counters and per-frame pattern latch
    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        x_d     = x_q;
        y_d     = y_q;
        mode_d  = mode_q;
        level_d = level_q;
        frame_d = frame_q;
        case (state_q)
            ST_IDLE: begin
                if (iRUN) begin
                    state_d = ST_VBLANK;
                    blk_d   = '0;
                end
            end
            ST_VBLANK: begin
                if (blk_q == BLK_W'(V_BLANK - 1)) begin
                    state_d = ST_ACTIVE;
                    blk_d   = '0;
                    x_d     = '0;
                    y_d     = '0;
                    mode_d  = mode_e'(iMODE);
                    level_d = iLEVEL;
                end else begin
                    blk_d = blk_q + BLK_W'(1);
                end
            end
            ST_ACTIVE: begin
                if (x_q == CNT_W'(H_ACTIVE - 1)) begin
                    state_d = ST_HBLANK;
                    x_d     = '0;
                    blk_d   = '0;
                end else begin
                    x_d = x_q + CNT_W'(1);
                end
            end
            ST_HBLANK: begin
                if (blk_q == BLK_W'(H_BLANK - 1)) begin
                    blk_d = '0;
                    if (y_q != CNT_W'(V_ACTIVE - 1)) begin
                        y_d     = y_q + CNT_W'(1);
                        state_d = ST_ACTIVE;
                    end else begin
                        y_d     = '0;
                        frame_d = frame_q + FC_W'(1);
                        state_d = iRUN ? ST_VBLANK : ST_IDLE;
                    end
                end else begin
                    blk_d = blk_q + BLK_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef BAYER_GEN_LFSR_EN
    logic [PIX_W-1:0] lfsr_q, lfsr_d;

    // Noise state: seeded as row 0 starts, one step after every active pixel
    always_comb begin
        lfsr_d = lfsr_q;
        if (state_q == ST_VBLANK && state_d == ST_ACTIVE) begin
            lfsr_d = LFSR_SEED;
        end else if (state_q == ST_ACTIVE) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    // Noise state register
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`endif

    bayer_pattern_gen #(
        .H_ACTIVE (H_ACTIVE)
    ) u_pattern (
        .mode   (mode_d),
        .x      (x_d),
        .y      (y_d),
        .level  (level_d),
`ifdef BAYER_GEN_LFSR_EN
        .lfsr   (lfsr_d),
`endif
        .pix_c  (pix_c)
    );

    // Outputs follow the next state so they line up with it after the edge
    always_comb begin
        dval_d = (state_d == ST_ACTIVE);
        fval_d = dval_d || (state_d == ST_HBLANK && y_d != CNT_W'(V_ACTIVE - 1));
        data_d = dval_d ? pix_c : '0;
    end

    // State, counter and output registers
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q <= ST_IDLE;
            blk_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            mode_q  <= MODE_SOLID;
            level_q <= '0;
            frame_q <= '0;
            data_q  <= '0;
            dval_q  <= 1'b0;
            fval_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            x_q     <= x_d;
            y_q     <= y_d;
            mode_q  <= mode_d;
            level_q <= level_d;
            frame_q <= frame_d;
            data_q  <= data_d;
            dval_q  <= dval_d;
            fval_q  <= fval_d;
        end
    end

    assign oDATA       = data_q;
    assign oDVAL       = dval_q;
    assign oX_Cont     = x_q;
    assign oY_Cont     = y_q;
    assign oFVAL       = fval_q;
    assign oFrame_Cont = frame_q;

endmodule
